// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit_pkg : op encodings, FSM states and iteration count for  |
// |                    the iterative multiply/divide unit                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mul_div_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // 33-bit magnitude so that |-2^31| stays representable
  function automatic logic [32:0] mag33(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) return -{1'b1, x};
    return {1'b0, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit : 32-iteration shift-add multiplier / restoring divider |
// |                with HI/LO result registers and MTHI/MTLO writes      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [32:0] r_opnd;
  logic [64:0] r_acc;
  logic        r_neg_a;
  logic        r_neg_b;

  logic        w_in_signed;
  logic        w_in_div;
  logic [32:0] w_mag_a;
  logic [32:0] w_mag_b;
  logic        w_is_div;
  logic [32:0] w_sum;
  logic [64:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic [33:0] w_diff;
  logic [64:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_dz;

  assign w_in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_in_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_mag_a     = mag33(A, w_in_signed);
  assign w_mag_b     = mag33(B, w_in_signed);
  assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);

  // Multiply: r_acc = {partial product high, multiplier bits shifting out}
  assign w_sum      = r_acc[64:32] + (r_acc[0] ? r_opnd : 33'd0);
  assign w_mul_next = {1'b0, w_sum, r_acc[31:1]};

  // Divide: r_acc = {remainder, dividend bits shifting in / quotient bits}
  assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
  assign w_diff     = {1'b0, w_rem_sh} - {1'b0, r_opnd};
  assign w_div_next = w_diff[33] ? {w_rem_sh, r_acc[30:0], 1'b0}
                                 : {w_diff[32:0], r_acc[30:0], 1'b1};

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc[63:0] : r_acc[63:0];
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_neg_a ? -r_acc[63:32] : r_acc[63:32];
  assign w_dz   = (r_opnd == 33'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= OP_MULT;
      r_a      <= 32'd0;
      r_opnd   <= 33'd0;
      r_acc    <= 65'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CALC;
            r_cnt   <= 6'd0;
            r_op    <= op;
            r_a     <= A;
            r_neg_a <= w_in_signed & A[31];
            r_neg_b <= w_in_signed & B[31];
            busy    <= 1'b1;
            if (w_in_div) begin
              r_acc  <= {33'd0, w_mag_a[31:0]};
              r_opnd <= w_mag_b;
            end else begin
              r_acc  <= {33'd0, w_mag_b[31:0]};
              r_opnd <= w_mag_a;
            end
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          if (!w_is_div) begin
            {HI, LO} <= w_prod;
          end else if (w_dz) begin
            HI       <= r_a;
            LO       <= 32'hFFFF_FFFF;
            div_zero <= 1'b1;
          end else begin
            HI <= w_rem;
            LO <= w_quo;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_div_unit : randomized scoreboard bench for mul_div_unit       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [64:0] q_exp[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        prev_done = 1'b0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference behaviour from plain integer arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    case (o)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      default:  p = '0;
    endcase
    eh = p[63:32];
    el = p[31:0];
    if (o == OP_DIV || o == OP_DIVU) begin
      if (b == 32'd0) begin
        eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
      end else begin
        if (o == OP_DIVU) begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        el = q[31:0];
        eh = r[31:0];
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [64:0] e;
    if (done) begin
      if (q_exp.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q_exp.pop_front();
        check("HI", {32'd0, HI}, {32'd0, e[64:33]});
        check("LO", {32'd0, LO}, {32'd0, e[32:1]});
        check("div_zero", {63'd0, div_zero}, {63'd0, e[0]});
      end
      if (prev_done) check("done_one_cycle", 64'd1, 64'd0);
    end else if (div_zero) begin
      check("div_zero_without_done", 64'd1, 64'd0);
    end
    prev_done <= done;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic wr_with_start);
    logic [31:0] eh, el;
    logic ez;
    int n, busy_n;
    bit seen, stable;
    logic busy_at_done;
    model(o, a, b, eh, el, ez);
    q_exp.push_back({eh, el, ez});
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    hi_we = wr_with_start; lo_we = wr_with_start; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n = 1; seen = 0; busy_n = 0; stable = 1; busy_at_done = 1'b1;
    while (n <= 40 && !seen) begin
      if (done) begin
        seen = 1;
        busy_at_done = busy;
      end else begin
        if (busy) busy_n++;
        if (HI !== m_hi || LO !== m_lo) stable = 0;
      end
      if (n == inj) begin
        start = 1'b1; op = ~o; A = $urandom; B = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (!seen) begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("done_latency", seen ? 64'(n) : 64'hFFFF, 64'd34);
    check("busy_cycles", 64'(busy_n), 64'd33);
    check("busy_low_at_done", {63'd0, busy_at_done}, 64'd0);
    check("hilo_stable_while_busy", {63'd0, stable}, 64'd1);
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_HI", {32'd0, HI}, 64'd0);
    check("rst_LO", {32'd0, LO}, 64'd0);
    reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    run_op(OP_DIVU,  32'd7, 32'd2, 0, 1'b0);
    run_op(OP_DIVU,  32'h0000_0064, 32'd0, 0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FF00, 32'd0, 0, 1'b0);

    // Start and MTHI/MTLO during busy must be ignored
    run_op(OP_MULTU, 32'h0001_0003, 32'h0000_0F00, 5, 1'b0);
    // Start wins over a simultaneous write
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_HI", {32'd0, HI}, 64'h1234_5678);
    check("mthi_LO_kept", {32'd0, LO}, {32'd0, m_lo});
    m_hi = 32'h1234_5678;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_HI", {32'd0, HI}, 64'hA5A5_0F0F);
    check("mthilo_LO", {32'd0, LO}, 64'hA5A5_0F0F);
    m_hi = 32'hA5A5_0F0F; m_lo = 32'hA5A5_0F0F;

    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 1'b0);
    end

    // Reset mid-DIV: no done afterwards, next op normal
    @(negedge clk);
    start = 1'b1; op = OP_DIV; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_HI", {32'd0, HI}, 64'd0);
    check("abort_LO", {32'd0, LO}, 64'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    run_op(OP_MULTU, 32'd3, 32'd5, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q_exp.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
